// File: rtl/cache_types.sv
// Shared cache-side types: line adaptor state encoding, line geometry and a
// saturating counter helper.
package cache_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

    localparam int LINE_BEATS       = 4;
    localparam int LINE_OFFSET_BITS = 5;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/line_shift_buffer.sv
// Line-wide staging buffer viewed as BEATS burst-wide slots: parallel load of a
// whole line, beat-indexed write for fetches, beat-indexed read for writebacks.
module line_shift_buffer #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    localparam int BEATS      = LINE_WIDTH / BURST_WIDTH,
    localparam int IDX_W      = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LINE_WIDTH-1:0]  load_line,
    input  logic                   beat_we,
    input  logic [IDX_W-1:0]       beat_idx,
    input  logic [BURST_WIDTH-1:0] beat_wdata,
    output logic [BURST_WIDTH-1:0] beat_rdata,
    output logic [LINE_WIDTH-1:0]  line
);

    logic [BEATS-1:0][BURST_WIDTH-1:0] slots;

    // NOTE: the slots are plain flops, not a RAM macro, so they take the reset
    // and line_o reads as zero until the first fetch; use <= so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else if (load) begin
            slots <= load_line;
        end else if (beat_we) begin
            slots[beat_idx] <= beat_wdata;
        end
    end

    assign beat_rdata = slots[beat_idx];
    assign line       = slots;

endmodule

// File: rtl/line_burst_adaptor.sv
// Memory-side responder: turns cache line read/write requests into 4-beat bursts.
// Optional LINE_ADAPTOR_STATS_EN adds saturating read/write/stall counters.
module line_burst_adaptor
    import cache_types::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
`ifdef LINE_ADAPTOR_STATS_EN
    ,
    output logic [31:0]            stat_reads,
    output logic [31:0]            stat_writes,
    output logic [31:0]            stat_wait_cycles
`endif
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int IDX_W = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    adaptor_state_t   state;
    adaptor_state_t   next_state;
    logic [IDX_W-1:0] count;
    logic             busy;
    logic             beat_ack;
    logic             last_beat;
    logic             accept;
    logic             unused_addr_bits;

    assign busy      = (state == READ) || (state == WRITE);
    assign beat_ack  = busy && resp_i;
    assign last_beat = beat_ack && (count == LAST_BEAT);
    assign accept    = (state == IDLE) && (read_i || write_i);

    // Offset bits are dropped: bursts always start on a line boundary.
    assign unused_addr_bits = ^address_i[LINE_OFFSET_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    next_state = WRITE;
                end else if (read_i) begin
                    next_state = READ;
                end
            end
            READ, WRITE: begin
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        case (state)
            READ:    read_o  = 1'b1;
            WRITE:   write_o = 1'b1;
            DONE:    resp_o  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address_o <= '0;
            count     <= '0;
        end else if (accept) begin
            address_o <= {address_i[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            count     <= '0;
        end else if (beat_ack) begin
            count <= count + IDX_W'(1);
        end
    end

    line_shift_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BURST_WIDTH(BURST_WIDTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == IDLE) && write_i),
        .load_line (line_i),
        .beat_we   ((state == READ) && resp_i),
        .beat_idx  (count),
        .beat_wdata(burst_i),
        .beat_rdata(burst_o),
        .line      (line_o)
    );

`ifdef LINE_ADAPTOR_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads       <= '0;
            stat_writes      <= '0;
            stat_wait_cycles <= '0;
        end else begin
            if ((state == READ) && last_beat) begin
                stat_reads <= sat_inc32(stat_reads);
            end
            if ((state == WRITE) && last_beat) begin
                stat_writes <= sat_inc32(stat_writes);
            end
            if (busy && !resp_i) begin
                stat_wait_cycles <= sat_inc32(stat_wait_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: directed vector table, reset
// mid-burst sequence, and randomized transactions against a line-level model.
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;
`ifdef LINE_ADAPTOR_STATS_EN
    logic [31:0]  stat_reads;
    logic [31:0]  stat_writes;
    logic [31:0]  stat_wait_cycles;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_reads  = 0;
    logic [31:0] exp_writes = 0;
    logic [31:0] exp_waits  = 0;

    line_burst_adaptor dut (
        .clk      (clk),
        .rst      (rst),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .line_i   (line_i),
        .line_o   (line_o),
        .resp_o   (resp_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .burst_o  (burst_o),
        .burst_i  (burst_i),
        .resp_i   (resp_i)
`ifdef LINE_ADAPTOR_STATS_EN
        ,
        .stat_reads      (stat_reads),
        .stat_writes     (stat_writes),
        .stat_wait_cycles(stat_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] data;
        logic [15:0]  pat;
        int           plen;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_stats();
`ifdef LINE_ADAPTOR_STATS_EN
        check("stat_reads", stat_reads, exp_reads);
        check("stat_writes", stat_writes, exp_writes);
        check("stat_wait_cycles", stat_wait_cycles, exp_waits);
`endif
    endtask

    // Runs one line transaction starting at a negedge with the DUT idle; ends at
    // the negedge after the resp_o pulse so the next call is back-to-back.
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [255:0] data,
                          input logic [15:0] pat, input int plen, input bit noisy);
        int   beats;
        int   j;
        int   waits;
        bit   is_wr;
        logic r;
        is_wr     = wr;
        write_i   = wr;
        read_i    = rd;
        address_i = addr;
        line_i    = wr ? data : rand256();
        resp_i    = 1'b0;
        @(negedge clk);
        check("address_o", address_o, exp_addr);
        beats = 0;
        j     = 0;
        waits = 0;
        while (beats < 4 && j < 64) begin
            r = (j < plen) ? pat[j[3:0]] : 1'b1;
            check("busy {read_o,write_o,resp_o}", {read_o, write_o, resp_o},
                  is_wr ? 3'b010 : 3'b100);
            if (is_wr) check("burst_o", burst_o, data[beats*64 +: 64]);
            resp_i  = r;
            burst_i = (!is_wr && r) ? data[beats*64 +: 64] : rand256();
            if (r) beats++;
            else   waits++;
            j++;
            @(negedge clk);
        end
        check("beats completed in budget", beats, 4);
        check("done {read_o,write_o,resp_o}", {read_o, write_o, resp_o}, 3'b001);
        if (!is_wr) check("line_o at resp", line_o, data);
        if (is_wr) exp_writes++;
        else       exp_reads++;
        exp_waits += waits;
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = noisy ? 1'($urandom) : 1'b0;
        burst_i = rand256();
        @(negedge clk);
        check("after {read_o,write_o,resp_o}", {read_o, write_o, resp_o}, 3'b000);
        if (!is_wr) check("line_o stable", line_o, data);
        check_stats();
        resp_i = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_1234, exp_addr: 32'h0000_1220,
                    data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    pat: 16'h0, plen: 0};
        vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_ABCF, exp_addr: 32'h0000_ABC0,
                    data: {64'hDEAD_0003_BEEF_0003, 64'hDEAD_0002_BEEF_0002,
                           64'hDEAD_0001_BEEF_0001, 64'hDEAD_0000_BEEF_0000},
                    pat: 16'h0, plen: 0};
        vecs[2] = '{wr: 1'b0, rd: 1'b1, addr: 32'h8000_003F, exp_addr: 32'h8000_0020,
                    data: {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
                           64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001},
                    pat: 16'b101_1001, plen: 7};
        vecs[3] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_2010, exp_addr: 32'h0000_2000,
                    data: {64'h0BAD_F00D_0000_0003, 64'h0BAD_F00D_0000_0002,
                           64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0000},
                    pat: 16'b10, plen: 2};
        vecs[4] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_3041, exp_addr: 32'h0000_3040,
                    data: {64'hC0FF_EE00_0000_0013, 64'hC0FF_EE00_0000_0012,
                           64'hC0FF_EE00_0000_0011, 64'hC0FF_EE00_0000_0010},
                    pat: 16'h0, plen: 0};
        vecs[5] = '{wr: 1'b1, rd: 1'b1, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFE0,
                    data: {64'h5555_0000_5555_0003, 64'h5555_0000_5555_0002,
                           64'h5555_0000_5555_0001, 64'h5555_0000_5555_0000},
                    pat: 16'h0, plen: 0};

        rst       = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset {read_o,write_o,resp_o}", {read_o, write_o, resp_o}, 3'b000);
        check("reset address_o", address_o, 32'h0);
        check("reset line_o", line_o, 256'h0);
        check("reset burst_o", burst_o, 64'h0);
        check_stats();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].exp_addr,
                   vecs[i].data, vecs[i].pat, vecs[i].plen, 1'b0);
        end

        // Reset after two beats of a read: outputs drop at once, partial line lost.
        read_i    = 1'b1;
        address_i = 32'h4444_0047;
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
        @(negedge clk);
        resp_i = 1'b0;
        check("pre-reset read_o", read_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid-burst reset {read_o,write_o,resp_o}", {read_o, write_o, resp_o}, 3'b000);
        check("mid-burst reset line_o", line_o, 256'h0);
        read_i = 1'b0;
        @(negedge clk);
        check("held reset resp_o", resp_o, 1'b0);
        rst        = 1'b0;
        exp_reads  = 0;
        exp_writes = 0;
        exp_waits  = 0;
        do_txn(1'b0, 1'b1, 32'h4444_0047, 32'h4444_0040,
               {64'hD4D4_D4D4_0000_0004, 64'hD3D3_D3D3_0000_0003,
                64'hD2D2_D2D2_0000_0002, 64'hD1D1_D1D1_0000_0001},
               16'h0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          gap;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a    = $urandom;
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                resp_i  = 1'($urandom);
                burst_i = rand256();
                @(negedge clk);
                check("idle {read_o,write_o,resp_o}", {read_o, write_o, resp_o}, 3'b000);
            end
            resp_i = 1'b0;
            do_txn(kind != 0, kind != 1, a, a & 32'hFFFF_FFE0, rand256(),
                   16'($urandom), $urandom_range(0, 12), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
